rv16_fetch_unit: RTL



---
 rtl/rv16_fetch_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/rv16_fetch_unit.sv
// ---------------------------------------------------------------------------
// rv16_fetch_unit
//
// Instruction-fetch front end for the RV16 pipeline. It drives a synchronous
// instruction memory (data returns one cycle after the request), buffers the
// returned words with their PCs in a DEPTH-entry prefetch queue, and hands
// them to decode with a valid/ready handshake. A taken-branch redirect
// flushes the queue, discards any response still in flight and restarts
// fetch at the target. The target is clamped to PC_LIMIT. Fetch halts after
// PC_LIMIT has been issued.
//
// Parameters
//   XLEN      PC / instruction width
//   DEPTH     prefetch queue entries (power of two, >= 2)
//   PC_LIMIT  highest fetchable address
//
// Ports
//   i_clk             clock, all state on rising edge
//   i_rst             asynchronous reset, active low
//   o_imem_req        instruction read request this cycle
//   o_imem_addr       read address (current PC)
//   i_imem_rdata      read data, valid one cycle after o_imem_req
//   i_redirect_valid  taken branch: flush and refetch
//   i_redirect_pc     branch target
//   o_id_valid        queue head valid
//   o_id_instr        head instruction
//   o_id_pc           head PC
//   i_id_ready        decode accepts head (low = stall)
//   o_queue_count     entries currently held
//
// Optional build macro RV16_FETCH_PERF_EN adds two saturating 16-bit counters:
//   o_redirect_cnt    cycles with i_redirect_valid
//   o_stall_cnt       cycles with o_id_valid & !i_id_ready
// ---------------------------------------------------------------------------
module rv16_fetch_unit #(
  parameter int              XLEN     = 16,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] PC_LIMIT = 16'h0FFF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  output logic                       o_imem_req,
  output logic [XLEN-1:0]            o_imem_addr,
  input  logic [XLEN-1:0]            i_imem_rdata,
  input  logic                       i_redirect_valid,
  input  logic [XLEN-1:0]            i_redirect_pc,
  output logic                       o_id_valid,
  output logic [XLEN-1:0]            o_id_instr,
  output logic [XLEN-1:0]            o_id_pc,
  input  logic                       i_id_ready,
  output logic [$clog2(DEPTH+1)-1:0] o_queue_count
`ifdef RV16_FETCH_PERF_EN
  ,
  output logic [15:0]                o_redirect_cnt,
  output logic [15:0]                o_stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_req_pc;

  logic [XLEN-1:0] r_qinstr [DEPTH];
  logic [XLEN-1:0] r_qpc    [DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic            w_pop;
  logic            w_kill;
  logic            w_push;
  logic [CW:0]     w_occ;
  logic            w_issue;
  logic [XLEN-1:0] w_target;

  // Handshake, kill and issue decisions. A redirect overrides everything in
  // its cycle: no pop, the in-flight response is killed and no new request
  // goes out. The request is combinational because the redirect has to
  // suppress it in the same cycle.
  always_comb begin
    w_pop    = o_id_valid & i_id_ready & ~i_redirect_valid;
    w_kill   = r_inflight & i_redirect_valid;
    w_push   = r_inflight & ~w_kill;
    // Slots already promised: held entries plus the response on its way,
    // minus the entry leaving this cycle.
    w_occ    = {1'b0, r_count} + {{CW{1'b0}}, r_inflight} - {{CW{1'b0}}, w_pop};
    w_issue  = (r_state == ST_RUN) & ~i_redirect_valid & (w_occ < (CW+1)'(DEPTH));
    w_target = (i_redirect_pc > PC_LIMIT) ? PC_LIMIT : i_redirect_pc;
  end

  assign o_imem_req    = w_issue;
  assign o_imem_addr   = r_pc;
  assign o_queue_count = r_count;
  assign o_id_valid    = (r_count != '0);
  // Storage is not reset, so the head is masked while the queue is empty.
  assign o_id_instr    = o_id_valid ? r_qinstr[r_head] : '0;
  assign o_id_pc       = o_id_valid ? r_qpc[r_head]    : '0;

  // Fetch state machine and PC. After issuing PC_LIMIT the PC parks there
  // and only a redirect restarts fetching.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= ST_RESET;
      r_pc       <= '0;
      r_inflight <= 1'b0;
      r_req_pc   <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_pc;
      end
      if (i_redirect_valid) begin
        r_state <= ST_RUN;
        r_pc    <= w_target;
      end else begin
        case (r_state)
          ST_RESET: r_state <= ST_RUN;
          ST_RUN: begin
            if (w_issue) begin
              if (r_pc == PC_LIMIT) begin
                r_state <= ST_HALT;
              end else begin
                r_pc <= r_pc + XLEN'(1);
              end
            end
          end
          ST_HALT: r_state <= ST_HALT;
          default: r_state <= ST_RESET;
        endcase
      end
    end
  end

  // Queue pointers and occupancy. Pointers wrap naturally because DEPTH is
  // a power of two; the count alone tells full from empty.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_redirect_valid) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Queue storage: the response is tagged with the PC of the request that
  // produced it.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_qinstr[r_tail] <= i_imem_rdata;
      r_qpc[r_tail]    <= r_req_pc;
    end
  end

`ifdef RV16_FETCH_PERF_EN
  logic [15:0] r_redirect_cnt;
  logic [15:0] r_stall_cnt;

  // Saturating event counters for redirects and decode back-pressure.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_redirect_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      if (i_redirect_valid && (r_redirect_cnt != 16'hFFFF)) begin
        r_redirect_cnt <= r_redirect_cnt + 16'd1;
      end
      if (o_id_valid && !i_id_ready && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
    end
  end

  assign o_redirect_cnt = r_redirect_cnt;
  assign o_stall_cnt    = r_stall_cnt;
`endif

endmodule
